// File: rtl/psg_access_ctrl_pkg.sv
// rtl/psg_access_ctrl_pkg.sv - shared state encoding, requester ids and timing defaults
package psg_access_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      A_SET,
      A_STB,
      A_HLD,
      D_SET,
      D_STB,
      D_HLD,
      SETTLE,
      R_SET,
      R_STB,
      R_END
   } psg_state_t;

   localparam logic REQ_Z80 = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   localparam int DEF_STROBE_CYC = 2;
   localparam int DEF_SETTLE_CYC = 3;
   localparam bit DEF_ADDR_CACHE = 1'b1;

endpackage

// File: rtl/psg_access_ctrl_if.sv
// rtl/psg_access_ctrl_if.sv - requester handshake and ay8910 CPU-side bus bundle
interface psg_access_ctrl_if;

   logic       req0;
   logic       req1;
   logic       we0;
   logic       we1;
   logic [3:0] addr0;
   logic [3:0] addr1;
   logic [7:0] wdata0;
   logic [7:0] wdata1;
   logic       ack0;
   logic       ack1;
   logic [7:0] rdata;
   logic       busy;
   logic       psg_asel;
   logic       psg_cs_n;
   logic       psg_wr_n;
   logic       psg_rd_n;
   logic [7:0] psg_di;
   logic [7:0] psg_do;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, psg_do,
      input  ack0, ack1, rdata, busy, psg_asel, psg_cs_n, psg_wr_n, psg_rd_n, psg_di
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, psg_do,
      output ack0, ack1, rdata, busy, psg_asel, psg_cs_n, psg_wr_n, psg_rd_n, psg_di
   );

endinterface

// File: rtl/psg_access_ctrl_rr_arb.sv
// rtl/psg_access_ctrl_rr_arb.sv - two-way round-robin arbiter; last points at the latest grant
module psg_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       last
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      last <= 1'b1;
      else if (advance && (|gnt))      last <= gnt[1];
   end

endmodule

// File: rtl/psg_access_ctrl.sv
// rtl/psg_access_ctrl.sv - arbitrates two requesters onto the ay8910 bus with framed
// address/data strobes and a latched-address cache
module psg_access_ctrl
   import psg_access_ctrl_pkg::*;
#(
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter bit ADDR_CACHE = DEF_ADDR_CACHE
) (
   input  logic               clk,
   input  logic               rst_n,
   psg_access_ctrl_if.slave   bus
);

   localparam int CMAX = (STROBE_CYC > SETTLE_CYC) ? STROBE_CYC : SETTLE_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

   psg_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    gnt;
   logic          arb_last;
   logic          grant;
   logic          ack_pulse;
   logic          need_addr;
   logic          sel_we;
   logic [3:0]    sel_addr;
   logic [7:0]    sel_wdata;
   logic          l_we;
   logic [3:0]    l_addr;
   logic [7:0]    l_wdata;
   logic [7:0]    cur_wdata;
   logic          cache_vld;
   logic [3:0]    cache_addr;
   logic [7:0]    rdata_q;
   logic          asel_q, cs_n_q, wr_n_q, rd_n_q;
   logic [7:0]    di_q;

   assign grant = (state == IDLE) && (|gnt);

   psg_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({bus.req1, bus.req0}),
      .advance (grant),
      .gnt     (gnt),
      .last    (arb_last)
   );

   assign sel_we    = gnt[1] ? bus.we1    : bus.we0;
   assign sel_addr  = gnt[1] ? bus.addr1  : bus.addr0;
   assign sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
   assign need_addr = !ADDR_CACHE || !cache_vld || (cache_addr != sel_addr);
   // D_SET is entered straight from IDLE on a cache hit, before the latch holds the data
   assign cur_wdata = (state == IDLE) ? sel_wdata : l_wdata;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      ack_pulse = 1'b0;
      case (state)
         IDLE:   if (|gnt) state_nxt = need_addr ? A_SET : (sel_we ? D_SET : R_SET);
         A_SET:  state_nxt = A_STB;
         A_STB:  if (cnt == STB_LAST) state_nxt = A_HLD; else cnt_nxt = cnt + 1'b1;
         A_HLD:  state_nxt = l_we ? D_SET : R_SET;
         D_SET:  state_nxt = D_STB;
         D_STB:  if (cnt == STB_LAST) state_nxt = D_HLD; else cnt_nxt = cnt + 1'b1;
         D_HLD:  state_nxt = SETTLE;
         SETTLE: begin
            if (cnt == SET_LAST) begin
               ack_pulse = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         R_SET:  state_nxt = R_STB;
         R_STB:  if (cnt == STB_LAST) state_nxt = R_END; else cnt_nxt = cnt + 1'b1;
         R_END: begin
            ack_pulse = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         l_we       <= 1'b0;
         l_addr     <= 4'h0;
         l_wdata    <= 8'h00;
         cache_vld  <= 1'b0;
         cache_addr <= 4'h0;
         rdata_q    <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant) begin
            l_we    <= sel_we;
            l_addr  <= sel_addr;
            l_wdata <= sel_wdata;
         end
         if (state == A_HLD) begin
            cache_addr <= l_addr;
            cache_vld  <= 1'b1;
         end
         if ((state == R_STB) && (cnt == STB_LAST)) rdata_q <= bus.psg_do;
      end
   end

   // Bus pins are registered from the next state so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asel_q <= 1'b0;
         cs_n_q <= 1'b1;
         wr_n_q <= 1'b1;
         rd_n_q <= 1'b1;
         di_q   <= 8'h00;
      end else begin
         asel_q <= state_nxt inside {A_SET, A_STB, A_HLD};
         cs_n_q <= !(state_nxt inside {A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, R_SET, R_STB});
         wr_n_q <= !(state_nxt inside {A_STB, D_STB});
         rd_n_q <= (state_nxt != R_STB);
         if (state_nxt == A_SET)      di_q <= {4'h0, sel_addr};
         else if (state_nxt == D_SET) di_q <= cur_wdata;
      end
   end

   // The arbiter's last pointer always names the requester currently being served
   assign bus.ack0     = ack_pulse && (arb_last == REQ_Z80);
   assign bus.ack1     = ack_pulse && (arb_last == REQ_AUX);
   assign bus.rdata    = rdata_q;
   assign bus.busy     = (state != IDLE);
   assign bus.psg_asel = asel_q;
   assign bus.psg_cs_n = cs_n_q;
   assign bus.psg_wr_n = wr_n_q;
   assign bus.psg_rd_n = rd_n_q;
   assign bus.psg_di   = di_q;

endmodule

// File: tb/tb_psg_access_ctrl.sv
// tb/tb_psg_access_ctrl.sv - scoreboard bench with an ay8910 register model on the bus
module tb_psg_access_ctrl;
   import psg_access_ctrl_pkg::*;

   typedef struct {
      int         id;
      int         lat;
      bit         chk_rd;
      logic [7:0] rd;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   psg_access_ctrl_if bus ();

   psg_access_ctrl #(
      .STROBE_CYC (2),
      .SETTLE_CYC (3),
      .ADDR_CACHE (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       sb[$];
   exp_t       mon_e;
   int         mon_id;
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         issue_cyc [2];
   logic [7:0] m_reg [16];
   logic [3:0] m_addr   = 4'h0;
   logic [7:0] last_adi = 8'h00;
   int         a_cnt    = 0;
   int         rd_low   = 0;
   int         ack1_seen = 0;
   int         a0;
   int         n;

   always @(posedge clk) cyc <= cyc + 1;

   // ay8910 model: latches on the rising edge of wr_n while selected
   always @(posedge bus.psg_wr_n) begin
      if (rst_n && !bus.psg_cs_n) begin
         if (bus.psg_asel) begin
            m_addr   = bus.psg_di[3:0];
            last_adi = bus.psg_di;
            a_cnt    = a_cnt + 1;
         end else begin
            m_reg[m_addr] = bus.psg_di;
         end
      end
   end
   assign bus.psg_do = m_reg[m_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus.psg_rd_n) rd_low = rd_low + 1;
         if (bus.ack0 || bus.ack1) begin
            mon_id = bus.ack1 ? 1 : 0;
            if (bus.ack1) ack1_seen = ack1_seen + 1;
            check("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 0);
            check("ack_expected", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("ack_id", mon_id, mon_e.id);
               if (mon_e.lat > 0) check("ack_lat", cyc - issue_cyc[mon_id] + 1, mon_e.lat);
               if (mon_e.chk_rd) check("rdata", bus.rdata, mon_e.rd);
            end
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic expect_ack(input int id, input int lat, input bit chk, input logic [7:0] rd);
      exp_t e;
      e.id = id; e.lat = lat; e.chk_rd = chk; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic drive(input int id, input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit hold);
      int w;
      logic got;
      w = 0;
      got = 1'b0;
      issue_cyc[id] = cyc;
      if (id == 0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end
      while (!got && w < 200) begin
         @(negedge clk);
         w++;
         got = (id == 0) ? bus.ack0 : bus.ack1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL ack_timeout: requester %0d got no ack want ack within 200 cycles", id);
      end
      tick(1);
      if (!hold) begin
         if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = 4'h0; bus.addr1 = 4'h0; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
      tick(3);

      check("rst_cs_n",  bus.psg_cs_n, 1);
      check("rst_wr_n",  bus.psg_wr_n, 1);
      check("rst_rd_n",  bus.psg_rd_n, 1);
      check("rst_asel",  bus.psg_asel, 0);
      check("rst_di",    bus.psg_di,   0);
      check("rst_ack0",  bus.ack0,     0);
      check("rst_ack1",  bus.ack1,     0);
      check("rst_rdata", bus.rdata,    0);
      check("rst_busy",  bus.busy,     0);
      rst_n = 1'b1;
      tick(1);

      // 1: uncached write
      a0 = a_cnt;
      expect_ack(0, 12, 0, 8'h00);
      drive(0, 1'b1, 4'd7, 8'h38, 1'b0);
      check("t1_reg7", m_reg[7], 8'h38);
      check("t1_adi", last_adi, 8'h07);
      check("t1_acnt", a_cnt - a0, 1);
      check("t1_no_ack1", ack1_seen, 0);

      // 2: cached write skips the address phase
      a0 = a_cnt;
      expect_ack(0, 8, 0, 8'h00);
      drive(0, 1'b1, 4'd7, 8'h3F, 1'b0);
      check("t2_reg7", m_reg[7], 8'h3F);
      check("t2_acnt", a_cnt - a0, 0);

      // 3: simultaneous requests, then alternation after a lone req0
      do_reset();
      expect_ack(0, 12, 0, 8'h00);
      expect_ack(1, 24, 0, 8'h00);
      fork
         drive(0, 1'b1, 4'd0, 8'h11, 1'b0);
         drive(1, 1'b1, 4'd2, 8'h22, 1'b0);
      join
      expect_ack(0, 8, 0, 8'h00);
      drive(0, 1'b1, 4'd2, 8'h33, 1'b0);
      expect_ack(1, 8, 0, 8'h00);
      expect_ack(0, 20, 0, 8'h00);
      fork
         drive(0, 1'b1, 4'd0, 8'h44, 1'b0);
         drive(1, 1'b1, 4'd2, 8'h55, 1'b0);
      join
      check("t3_reg0", m_reg[0], 8'h44);
      check("t3_reg2", m_reg[2], 8'h55);

      // 4: write then cached read-back, plus addr 15 and reg 13 boundaries
      expect_ack(0, 12, 0, 8'h00);
      drive(0, 1'b1, 4'd8, 8'h0F, 1'b0);
      rd_low = 0;
      expect_ack(1, 5, 1, 8'h0F);
      drive(1, 1'b0, 4'd8, 8'h00, 1'b0);
      check("t4_rd_low", rd_low, 2);
      expect_ack(1, 12, 0, 8'h00);
      drive(1, 1'b1, 4'd15, 8'hAA, 1'b0);
      check("t4_adi15", last_adi, 8'h0F);
      check("t4_reg15", m_reg[15], 8'hAA);
      expect_ack(0, 12, 0, 8'h00);
      drive(0, 1'b1, 4'd13, 8'h0E, 1'b0);
      check("t4_reg13", m_reg[13], 8'h0E);

      // 5: reset during the data strobe
      a0 = a_cnt;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'h99;
      n = 0;
      while (!(bus.psg_asel == 1'b0 && bus.psg_wr_n == 1'b0 && bus.psg_cs_n == 1'b0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t5_reach_dstb", (n < 50) ? 1 : 0, 1);
      rst_n = 1'b0;
      #1;
      check("t5_cs_n", bus.psg_cs_n, 1);
      check("t5_wr_n", bus.psg_wr_n, 1);
      check("t5_busy", bus.busy, 0);
      bus.req0 = 1'b0;
      check("t5_reg3_untouched", m_reg[3], 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      expect_ack(0, 12, 0, 8'h00);
      drive(0, 1'b1, 4'd3, 8'h99, 1'b0);
      check("t5_acnt", a_cnt - a0, 2);
      check("t5_reg3", m_reg[3], 8'h99);

      // 6: req1 held for four accesses, req0 pulses once
      expect_ack(1, 12, 0, 8'h00);
      expect_ack(0, 22, 0, 8'h00);
      expect_ack(1, 0, 0, 8'h00);
      expect_ack(1, 0, 0, 8'h00);
      expect_ack(1, 0, 0, 8'h00);
      fork
         begin
            drive(1, 1'b1, 4'd5, 8'hA1, 1'b1);
            drive(1, 1'b1, 4'd5, 8'hA2, 1'b1);
            drive(1, 1'b1, 4'd5, 8'hA3, 1'b1);
            drive(1, 1'b1, 4'd5, 8'hA4, 1'b0);
         end
         begin
            tick(2);
            drive(0, 1'b1, 4'd6, 8'h66, 1'b0);
         end
      join
      check("t6_reg5", m_reg[5], 8'hA4);
      check("t6_reg6", m_reg[6], 8'h66);

      tick(5);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
